// File: rtl/om_alloc_recorder_if.sv
// Commit-stream and interval-write signals shared by the allocation recorder and its environment.
interface om_alloc_recorder_if;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic [31:0] commit_target;
   logic        commit_is_call;
   logic        commit_is_ret;
   logic        commit_is_compressed;
   logic [31:0] a0;
   logic        en_write;
   logic [31:0] addr_first;
   logic [31:0] addr_last;

   // Environment side: drives commits, observes interval writes.
   modport master (
      output commit_valid, commit_pc, commit_target, commit_is_call,
             commit_is_ret, commit_is_compressed, a0,
      input  en_write, addr_first, addr_last
   );

   // Recorder side: consumes commits, produces interval writes.
   modport slave (
      input  commit_valid, commit_pc, commit_target, commit_is_call,
             commit_is_ret, commit_is_compressed, a0,
      output en_write, addr_first, addr_last
   );
endinterface

// File: rtl/om_alloc_recorder.sv
// Allocation recorder: tracks a malloc call through to its matching return and
// writes the resulting {first, last} interval into the object-map buffer.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a committed call to MALLOC_ADDR
// IN_MALLOC | inside the allocator; counting nested calls and the timeout
// EMIT      | one cycle after the matching return; write strobe (if any) is up
module om_alloc_recorder #(
   parameter logic [31:0] MALLOC_ADDR = 32'h0000_1000,
   parameter int          TIMEOUT     = 4096,
   parameter int          DEPTH_W     = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   om_alloc_recorder_if.slave  bus,
   output logic                busy_o,
   output logic [7:0]          drop_cnt_o
);
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, IN_MALLOC, EMIT} state_t;

   state_t             state_q, state_d;
   logic [31:0]        size_q, size_d;
   logic [31:0]        ret_addr_q, ret_addr_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               en_write_q, en_write_d;
   logic [31:0]        addr_first_q, addr_first_d;
   logic [31:0]        addr_last_q, addr_last_d;
   logic [7:0]         drop_q, drop_d;

   logic               trigger;
   logic [32:0]        last_sum;

   assign trigger  = bus.commit_valid && bus.commit_is_call &&
                     (bus.commit_target == MALLOC_ADDR);
   // Inclusive end; only meaningful when size is non-zero, carry means clamp.
   assign last_sum = {1'b0, bus.a0} + {1'b0, size_q} - 33'd1;

   // Next-state and latch decisions; flush overrides everything at the end.
   always_comb begin
      state_d      = state_q;
      size_d       = size_q;
      ret_addr_d   = ret_addr_q;
      depth_d      = depth_q;
      timer_d      = timer_q;
      en_write_d   = 1'b0;
      addr_first_d = addr_first_q;
      addr_last_d  = addr_last_q;
      drop_d       = drop_q;

      case (state_q)
         IDLE, EMIT: begin
            state_d = IDLE;
            if (trigger) begin
               size_d     = bus.a0;
               ret_addr_d = bus.commit_pc + (bus.commit_is_compressed ? 32'd2 : 32'd4);
               depth_d    = '0;
               timer_d    = '0;
               state_d    = IN_MALLOC;
            end
         end
         IN_MALLOC: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TMR_LAST) begin
               state_d = IDLE;
               timer_d = '0;
               depth_d = '0;
               if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else if (bus.commit_valid && bus.commit_is_call) begin
               if (&depth_q) begin
                  // Nesting deeper than the counter can follow: treat as lost.
                  state_d = IDLE;
                  timer_d = '0;
                  depth_d = '0;
                  if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
               end else begin
                  depth_d = depth_q + 1'b1;
               end
            end else if (bus.commit_valid && bus.commit_is_ret) begin
               if (depth_q != '0) begin
                  depth_d = depth_q - 1'b1;
               end else if (bus.commit_target == ret_addr_q) begin
                  state_d = EMIT;
                  timer_d = '0;
                  // Write is registered here so the strobe sits in the EMIT cycle.
                  if (bus.a0 != 32'd0 && size_q != 32'd0) begin
                     en_write_d   = 1'b1;
                     addr_first_d = bus.a0;
                     addr_last_d  = last_sum[32] ? 32'hFFFF_FFFF : last_sum[31:0];
                  end
               end else begin
                  // Returned somewhere else (longjmp, corrupted stack): give up quietly.
                  state_d = IDLE;
                  timer_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush_i) begin
         state_d      = IDLE;
         depth_d      = '0;
         timer_d      = '0;
         en_write_d   = 1'b0;
         addr_first_d = addr_first_q;
         addr_last_d  = addr_last_q;
         drop_d       = drop_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         size_q       <= '0;
         ret_addr_q   <= '0;
         depth_q      <= '0;
         timer_q      <= '0;
         en_write_q   <= 1'b0;
         addr_first_q <= '0;
         addr_last_q  <= '0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         size_q       <= size_d;
         ret_addr_q   <= ret_addr_d;
         depth_q      <= depth_d;
         timer_q      <= timer_d;
         en_write_q   <= en_write_d;
         addr_first_q <= addr_first_d;
         addr_last_q  <= addr_last_d;
         drop_q       <= drop_d;
      end
   end

   assign bus.en_write   = en_write_q;
   assign bus.addr_first = addr_first_q;
   assign bus.addr_last  = addr_last_q;
   assign busy_o         = (state_q != IDLE);
   assign drop_cnt_o     = drop_q;
endmodule

// File: doc/om_alloc_recorder.md
Name: om_alloc_recorder

Overview:
- Watches the commit stream for calls to the allocator entry point (malloc).
- Captures the requested size at call commit and the returned pointer at the matching return commit.
- Emits one interval record {first, last} as a single-cycle write pulse into the object-map interval buffer.
- It is the write-side producer for that buffer; lookups stay with the buffer's consumers.

Parameters:
- MALLOC_ADDR, 32'h0000_1000, entry PC of the allocator; a call whose target equals this starts tracking.
- TIMEOUT, 4096, max cycles spent tracking one allocation before abort.
- DEPTH_W, 4, width of the nested-call depth counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  synchronous abort of any tracking (pipeline/context flush)
commit_valid_i  in  1  one instruction committed this cycle
commit_pc_i  in  32  PC of committed instruction
commit_target_i  in  32  control-transfer target of committed instruction
commit_is_call_i  in  1  committed instruction is a call (jal/jalr writing ra)
commit_is_ret_i  in  1  committed instruction is a return (jalr x0, ra)
commit_is_compressed_i  in  1  committed instruction is 16-bit
a0_i  in  32  architectural a0 at this commit
en_write_o  out  1  single-cycle write strobe to interval buffer
addr_first_o  out  32  interval base (returned pointer)
addr_last_o  out  32  interval end, inclusive
busy_o  out  1  high while state != IDLE
drop_cnt_o  out  8  saturating count of timed-out allocations

Behaviour:
- Reset (rst_i=1, async): state=IDLE; en_write_o=0; addr_first_o=0; addr_last_o=0; drop_cnt_o=0; depth=0; timer=0; latched size/ret_addr/ptr=0. All outputs are registered.
- A "commit" means commit_valid_i=1. Inputs are ignored when commit_valid_i=0, except that the timer still advances.
- States: IDLE, IN_MALLOC, EMIT.
- IDLE:
  - Trigger is a commit with is_call and target==MALLOC_ADDR.
  - On trigger: size<=a0_i; ret_addr<=commit_pc_i+(compressed?2:4); depth<=0; timer<=0; go to IN_MALLOC.
- IN_MALLOC, rules in priority order:
  - Timer increments every cycle. If timer reaches TIMEOUT-1: go to IDLE, no write, drop_cnt_o+1 (saturates at 255).
  - Commit with is_call (any target, including MALLOC_ADDR recursion): depth+1. If depth is already all-ones, abort to IDLE as a timeout (drop_cnt_o+1).
  - Commit with is_ret and depth!=0: depth-1.
  - Commit with is_ret, depth==0 and target==ret_addr: ptr<=a0_i; go to EMIT.
  - Commit with is_ret, depth==0 and target!=ret_addr (longjmp or corrupt stack): go to IDLE, no write, no drop count.
- EMIT (exactly one cycle):
  - If ptr!=0 and size!=0: en_write_o=1, addr_first_o=ptr, addr_last_o=ptr+size-1.
  - Sum is computed in 33 bits; on carry out, addr_last_o is clamped to 32'hFFFF_FFFF.
  - If ptr==0 (NULL) or size==0: en_write_o stays 0 and addr outputs hold their previous values.
  - Next state is IDLE. If the EMIT cycle itself commits a trigger call, the next state is IN_MALLOC with fresh latches, applying the IDLE trigger rule.
- Latency: en_write_o rises exactly 1 cycle after the matching-return commit cycle and is high for exactly 1 cycle.
- addr_first_o/addr_last_o update only on an emitted write and hold otherwise.
- flush_i=1 in any state: next state IDLE; depth and timer cleared; no write; drop_cnt_o unchanged. flush_i has priority over all commit events in the same cycle, including EMIT's pending write, which is suppressed.
- Reset mid-operation: immediate IDLE, tracked allocation discarded, en_write_o=0 from reset assertion.
- Records are never back-to-back: at least 2 cycles between en_write_o pulses. The buffer needs no ready/backpressure.
- busy_o is combinational from state (state!=IDLE).

Test Plan:
1. Call MALLOC_ADDR at pc 0x8000_0040 (32-bit) with a0=16; 5 cycles later ret to 0x8000_0044 with a0=0x8000_0100 -> en_write_o=1 next cycle only; first=0x8000_0100, last=0x8000_010F; busy_o low after.
2. Same as 1 but malloc internally does call, call, ret, ret before the final ret -> single write; inner rets do not emit; depth returns to 0.
3. ret with a0=0 (NULL), then separately size=0 with a0=0x8000_0200 -> no en_write_o pulses; state returns to IDLE.
4. Call then no ret for 4096 cycles -> busy_o falls at cycle 4096; drop_cnt_o=1; no write. A subsequent normal malloc still records correctly.
5. size=0x20, ptr=0xFFFF_FFF0 -> last=0xFFFF_FFFF (clamped). The EMIT cycle also commits a new malloc call with a0=8 -> second record captured correctly after its ret.
6. rst_i pulsed while IN_MALLOC, then flush_i asserted in the same cycle as a matching ret in another run -> no writes from either; all outputs at reset values after reset.
